pc_checkpoint_monitor: RTL and testbench
========================================

// Module: pc_checkpoint_monitor
// PURPOSE
//  Parametrised in-system checker for the MIPS core. It watches the fetch PC and a set of tapped
//  GPRs, and steps through a table of NUM_CKPT PC checkpoints in order. At each hit it compares
//  the masked register values against expected values. It reports pass or fail, with the failing
//  checkpoint and a fail code.
//  Sits beside mips, with pc=instr_addr and regs from proc.regs.data, and replaces hand-written
//  wait/display benches.
// PARAMETERS
//  NUM_CKPT  4       number of checkpoint table entries (>=1)
//  NUM_REGS  2       number of watched registers per checkpoint (>=1)
//  ADDR_W    32      PC width
//  DATA_W    32      register width
//  TIMEOUT   4096    max cycles between consecutive checkpoint hits (>=2)
//  END_PC    32'h0   PC value that marks program end (ra_init return target)
// PORTS
//  clk        in   1                  core clock, rising edge
//  reset      in   1                  asynchronous, active-low reset (asserted when 0)
//  cfg_we     in   1                  write checkpoint entry cfg_idx (accepted only in IDLE)
//  cfg_idx    in   $clog2(NUM_CKPT)   entry index
//  cfg_pc     in   ADDR_W             checkpoint PC
//  cfg_exp    in   NUM_REGS*DATA_W    expected values; reg k = bits [k*DATA_W +: DATA_W]
//  cfg_mask   in   NUM_REGS           1 = compare reg k at this checkpoint
//  start      in   1                  arm the monitor (IDLE/DONE only)
//  pc         in   ADDR_W             current fetch PC
//  regs       in   NUM_REGS*DATA_W    live register taps, same packing as cfg_exp
//  busy       out  1                  high in RUN
//  done       out  1                  high in PASS or FAIL
//  pass       out  1                  high in PASS
//  fail_code  out  2                  0 none, 1 data mismatch, 2 early END_PC, 3 timeout
//  ckpt_idx   out  $clog2(NUM_CKPT)   next expected checkpoint; failing one when in FAIL
//  mism_mask  out  NUM_REGS           regs that mismatched at the failing checkpoint
//  gap_cnt    out  $clog2(TIMEOUT+1)  cycles since last hit or start (saturating)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; table contents cleared (pc=0, exp=0, mask=0).
//  FSM states: IDLE, RUN, PASS, FAIL.
//   IDLE/PASS/FAIL -> RUN on start. This clears ckpt_idx, gap_cnt, mism_mask and fail_code.
//   In IDLE, a cfg_we in the same cycle as start is written first, so it is visible in RUN.
//   RUN, pc==tbl[ckpt_idx].pc:
//    compute mism[k] = mask[k] & (regs[k] != exp[k]), sampled on the same edge.
//    If mism != 0: -> FAIL, code 1, mism_mask=mism, ckpt_idx held.
//    Else if ckpt_idx==NUM_CKPT-1: -> PASS.
//    Else: ckpt_idx++ and gap_cnt=0.
//   RUN, no hit, pc==END_PC: -> FAIL, code 2.
//   RUN, no hit, gap_cnt==TIMEOUT-1: -> FAIL, code 3.
//  Priority within one cycle: checkpoint hit > END_PC > timeout.
//   If the last checkpoint's pc equals END_PC, the hit wins and the result is PASS.
//  Latency: all outputs are registered and reflect a hit/end/timeout one cycle after the sampling
//   edge. A checkpoint is consumed once per hit. Re-matching the same pc after advancing compares
//   against the next entry only.
//  Repeated PC: if tbl[i].pc==tbl[i+1].pc, consecutive cycles at that PC consume both entries in
//   order.
//  gap_cnt increments every RUN cycle without a hit and saturates at TIMEOUT. It holds in
//   PASS/FAIL and is 0 in IDLE.
//  cfg_we outside IDLE: ignored. start in RUN: ignored.
//  Reset mid-RUN: immediate return to IDLE and the table is cleared. The bench must reload the
//   table.
//  pass/done/fail_code are held until the next start or reset.
// TESTING
//  1 Load 4 ckpts (0x80020014/1c/28/30), regs match, then pc->0 -> pass=1 one cycle after
//    the 0x80020030 hit, fail_code=0.
//  2 Same, r3 wrong at ckpt 2 (mask=2'b11) -> FAIL, fail_code=1, ckpt_idx=2, mism_mask=2'b10.
//    Repeat with mask=2'b01 -> PASS.
//  3 pc reaches 0 after ckpt 1 -> FAIL, fail_code=2, ckpt_idx=2.
//  4 TIMEOUT=16, pc stalls at 0x80020018 after ckpt 0 -> FAIL on cycle 16 after the hit, code 3.
//  5 Async reset pulse mid-RUN -> outputs 0 without a clock edge. cfg_we during RUN has no effect
//    (check by rerun).
//  6 Last ckpt pc=0 (==END_PC), program hits ckpts 0..2 then pc=0 -> PASS, not code 2.

Source files
------------

// File: rtl/pc_checkpoint_monitor.sv
// pc_checkpoint_monitor
// In-system checker that sits beside the MIPS core. It follows the fetch PC through
// an ordered table of checkpoints. At each hit it compares the masked register taps
// against the expected values for that entry. The final verdict is pass or fail. A
// fail carries a code, the failing checkpoint index and the mask of mismatched regs.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | after reset; table writable, all status outputs zero
//   S_RUN  | armed; waiting for tbl[ckpt_idx].pc, counting the gap
//   S_PASS | every checkpoint matched; verdict held until start/reset
//   S_FAIL | mismatch, early END_PC or timeout; verdict held
module pc_checkpoint_monitor #(
  parameter int                NUM_CKPT = 4,
  parameter int                NUM_REGS = 2,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 4096,
  parameter logic [ADDR_W-1:0] END_PC   = '0,
  localparam int               IDX_W    = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1,
  localparam int               GAP_W    = $clog2(TIMEOUT + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [IDX_W-1:0]           cfg_idx,
  input  logic [ADDR_W-1:0]          cfg_pc,
  input  logic [NUM_REGS*DATA_W-1:0] cfg_exp,
  input  logic [NUM_REGS-1:0]        cfg_mask,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          pc,
  input  logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [1:0]                 fail_code,
  output logic [IDX_W-1:0]           ckpt_idx,
  output logic [NUM_REGS-1:0]        mism_mask,
  output logic [GAP_W-1:0]           gap_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_e;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_DATA    = 2'd1;
  localparam logic [1:0] FC_END     = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CKPT - 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_SAT   = GAP_W'(TIMEOUT);

  state_e state_q, state_d;

  logic [ADDR_W-1:0]          tbl_pc_q   [NUM_CKPT];
  logic [NUM_REGS*DATA_W-1:0] tbl_exp_q  [NUM_CKPT];
  logic [NUM_REGS-1:0]        tbl_mask_q [NUM_CKPT];

  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [1:0]          code_q, code_d;
  logic [NUM_REGS-1:0] mism_q, mism_d;

  logic [ADDR_W-1:0]          cur_pc;
  logic [NUM_REGS*DATA_W-1:0] cur_exp;
  logic [NUM_REGS-1:0]        cur_mask;
  logic                       hit;
  logic [NUM_REGS-1:0]        mism;

  // Checkpoint table: cleared on reset, writable only while idle. A write issued
  // together with start lands on the same edge, so the run already sees it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        tbl_pc_q[i]   <= '0;
        tbl_exp_q[i]  <= '0;
        tbl_mask_q[i] <= '0;
      end
    end else if (state_q == S_IDLE && cfg_we) begin
      tbl_pc_q[cfg_idx]   <= cfg_pc;
      tbl_exp_q[cfg_idx]  <= cfg_exp;
      tbl_mask_q[cfg_idx] <= cfg_mask;
    end
  end

  // Match the current PC against the pending entry and flag masked mismatches.
  always_comb begin
    cur_pc   = tbl_pc_q[idx_q];
    cur_exp  = tbl_exp_q[idx_q];
    cur_mask = tbl_mask_q[idx_q];
    hit      = (pc == cur_pc);
    mism     = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      mism[k] = cur_mask[k] & (regs[k*DATA_W +: DATA_W] != cur_exp[k*DATA_W +: DATA_W]);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and status update. A hit outranks END_PC, and END_PC outranks timeout.
  // The gap counter still advances on a no-hit failing cycle, so a timeout leaves it at TIMEOUT.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    code_d  = code_q;
    mism_d  = mism_q;
    case (state_q)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          gap_d   = '0;
          code_d  = FC_NONE;
          mism_d  = '0;
        end
      end
      S_RUN: begin
        if (hit) begin
          gap_d = '0;
          if (|mism) begin
            state_d = S_FAIL;
            code_d  = FC_DATA;
            mism_d  = mism;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_PASS;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          if (gap_q != GAP_SAT) gap_d = gap_q + GAP_W'(1);
          if (pc == END_PC) begin
            state_d = S_FAIL;
            code_d  = FC_END;
          end else if (gap_q == GAP_LIMIT) begin
            state_d = S_FAIL;
            code_d  = FC_TIMEOUT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status registers behind the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= '0;
      gap_q  <= '0;
      code_q <= FC_NONE;
      mism_q <= '0;
    end else begin
      idx_q  <= idx_d;
      gap_q  <= gap_d;
      code_q <= code_d;
      mism_q <= mism_d;
    end
  end

  // Output decode straight from registered state.
  always_comb begin
    busy      = (state_q == S_RUN);
    done      = (state_q == S_PASS) || (state_q == S_FAIL);
    pass      = (state_q == S_PASS);
    fail_code = code_q;
    ckpt_idx  = idx_q;
    mism_mask = mism_q;
    gap_cnt   = gap_q;
  end

endmodule

// File: tb/tb_pc_checkpoint_monitor.sv
// Directed bench for pc_checkpoint_monitor. Each run pushes its expected verdict onto a
// scoreboard at arm time. The verdict is popped and compared once done rises.
module tb_pc_checkpoint_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_pc = '0;
  logic [63:0] cfg_exp = '0;
  logic [1:0]  cfg_mask = '0;
  logic        start = 1'b0;
  logic [31:0] pc = 32'h1;
  logic [63:0] regs = '0;
  logic        busy, done, pass;
  logic [1:0]  fail_code, ckpt_idx, mism_mask;
  logic [4:0]  gap_cnt;

  always #5 clk = ~clk;

  pc_checkpoint_monitor #(
    .NUM_CKPT(4), .NUM_REGS(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .END_PC(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pc(cfg_pc),
    .cfg_exp(cfg_exp), .cfg_mask(cfg_mask), .start(start), .pc(pc), .regs(regs),
    .busy(busy), .done(done), .pass(pass), .fail_code(fail_code), .ckpt_idx(ckpt_idx),
    .mism_mask(mism_mask), .gap_cnt(gap_cnt)
  );

  typedef struct packed {
    logic       p;
    logic [1:0] code;
    logic [1:0] idx;
    logic [1:0] mism;
  } res_t;

  res_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ck_pc  [4];
  logic [63:0] ck_exp [4];

  function automatic res_t mk(logic p, logic [1:0] c, logic [1:0] i, logic [1:0] m);
    return {p, c, i, m};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cfg_we = 1'b0;
    start  = 1'b0;
    reset  = 1'b0;
    #3;
    check("reset_outs", {busy, done, pass, fail_code, ckpt_idx, mism_mask, gap_cnt}, '0);
    step();
    reset = 1'b1;
  endtask

  task automatic load_table(input logic [1:0] mask);
    for (int i = 0; i < 4; i++) begin
      cfg_we = 1'b1; cfg_idx = 2'(i); cfg_pc = ck_pc[i]; cfg_exp = ck_exp[i]; cfg_mask = mask;
      step();
    end
    cfg_we = 1'b0;
  endtask

  task automatic arm(input res_t e);
    pc = 32'h8002_0000;
    start = 1'b1;
    step();
    start = 1'b0;
    sb_q.push_back(e);
    check("arm_state", {busy, done, pass, fail_code, ckpt_idx, mism_mask, gap_cnt}, 14'h2000);
  endtask

  task automatic hit(input int i, input logic bad_r3);
    pc   = ck_pc[i];
    regs = ck_exp[i] ^ (bad_r3 ? 64'h0000_0001_0000_0000 : 64'h0);
    step();
    regs = '0;
  endtask

  task automatic filler(input int n, input logic [31:0] addr);
    pc = addr;
    repeat (n) step();
  endtask

  task automatic wait_done(input string tag, input int budget);
    res_t e;
    int   k = 0;
    while (!done && k < budget) begin
      step();
      k++;
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_sb_nonempty"}, (sb_q.size() > 0), 1'b1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_verdict"}, {pass, fail_code, ckpt_idx, mism_mask}, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ck_pc[0] = 32'h8002_0014; ck_pc[1] = 32'h8002_001c;
    ck_pc[2] = 32'h8002_0028; ck_pc[3] = 32'h8002_0030;
    for (int i = 0; i < 4; i++) ck_exp[i] = {32'h300 + 32'(i), 32'h200 + 32'(i)};
    #2;

    // 1: all checkpoints match, verdict one cycle after the last hit
    do_reset();
    load_table(2'b11);
    arm(mk(1'b1, 2'd0, 2'd3, 2'b00));
    filler(1, 32'h8002_0004);
    check("t1_gap_one", gap_cnt, 5'd1);
    hit(0, 1'b0);
    check("t1_adv0", {ckpt_idx, gap_cnt}, {2'd1, 5'd0});
    step();  // pc held on entry 0's address: must not re-hit against entry 1
    check("t1_nohit_repeat", {busy, ckpt_idx, gap_cnt}, {1'b1, 2'd1, 5'd1});
    hit(1, 1'b0);
    filler(2, 32'h8002_0020);
    check("t1_gap_two", gap_cnt, 5'd2);
    hit(2, 1'b0);
    hit(3, 1'b0);
    check("t1_pass_latency", {done, pass, busy}, 3'b110);
    filler(1, 32'h0);
    check("t1_pass_held", {done, pass, fail_code}, 4'b1100);
    wait_done("t1", 4);

    // 2a: r3 wrong at checkpoint 2, both regs compared
    arm(mk(1'b0, 2'd1, 2'd2, 2'b10));
    hit(0, 1'b0);
    hit(1, 1'b0);
    filler(1, 32'h8002_0020);
    hit(2, 1'b1);
    check("t2a_fail_latency", {done, pass}, 2'b10);
    wait_done("t2a", 4);

    // 2b: same fault, r3 masked out
    do_reset();
    load_table(2'b01);
    arm(mk(1'b1, 2'd0, 2'd3, 2'b00));
    hit(0, 1'b0);
    hit(1, 1'b0);
    hit(2, 1'b1);
    hit(3, 1'b0);
    wait_done("t2b", 4);

    // 3: program returns after checkpoint 1
    arm(mk(1'b0, 2'd2, 2'd2, 2'b00));
    hit(0, 1'b0);
    hit(1, 1'b0);
    filler(2, 32'h8002_0020);
    filler(1, 32'h0);
    check("t3_end_latency", {done, fail_code}, 3'b110);
    wait_done("t3", 4);

    // 4: stall after checkpoint 0 until timeout
    arm(mk(1'b0, 2'd3, 2'd1, 2'b00));
    hit(0, 1'b0);
    filler(15, 32'h8002_0018);
    check("t4_before_timeout", {done, gap_cnt}, {1'b0, 5'd15});
    step();
    check("t4_timeout_edge", {done, fail_code, gap_cnt}, {1'b1, 2'd3, 5'd16});
    step();
    check("t4_gap_held", gap_cnt, 5'd16);
    wait_done("t4", 4);

    // 5: async reset mid-run, then cfg_we during RUN must be ignored
    pc = 32'h8002_0000;
    start = 1'b1;
    step();
    start = 1'b0;
    hit(0, 1'b0);
    filler(1, 32'h8002_0018);
    check("t5_running", {busy, ckpt_idx}, 3'b101);
    @(posedge clk);
    #2 reset = 1'b0;
    #2 check("t5_async_reset", {busy, done, pass, fail_code, ckpt_idx, mism_mask, gap_cnt}, '0);
    #1 reset = 1'b1;
    load_table(2'b11);
    arm(mk(1'b1, 2'd0, 2'd3, 2'b00));
    hit(0, 1'b0);
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_pc = 32'h8002_0040; cfg_exp = '0; cfg_mask = 2'b11;
    step();
    cfg_we = 1'b0;
    hit(1, 1'b0);
    hit(2, 1'b0);
    hit(3, 1'b0);
    wait_done("t5", 4);

    // 6: last checkpoint sits on END_PC, written in the same cycle as start
    do_reset();
    load_table(2'b11);
    ck_pc[3] = 32'h0;
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_pc = ck_pc[3]; cfg_exp = ck_exp[3]; cfg_mask = 2'b11;
    pc = 32'h8002_0000;
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_we = 1'b0;
    sb_q.push_back(mk(1'b1, 2'd0, 2'd3, 2'b00));
    hit(0, 1'b0);
    hit(1, 1'b0);
    hit(2, 1'b0);
    hit(3, 1'b0);
    check("t6_end_hit_pass", {done, pass, fail_code}, 4'b1100);
    wait_done("t6", 4);

    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
